// File: rtl/ssp_rx_logic.sv
// ssp_rx_logic: TI-style synchronous serial receive front end; deserialises MSB-first frames into RxFIFO.
// Optional macro SSP_RX_SYNC_EN inserts a 2-flop synchroniser ahead of the input capture stage.
module ssp_rx_logic #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    input  logic                  VALID,
    input  logic                  RXOVR_CLR,
    output logic [DATA_WIDTH-1:0] RxDATA,
    output logic                  RECV,
    output logic                  RXOVR,
    output logic                  RXBUSY
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [2:0]            pins;  // {clk, fss, rxd} as seen by the capture stage
    logic                  clk_q, fss_q, rxd_q, clk_prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic                  recv_q, recv_d, ovr_q, ovr_d;
    logic                  sample, last_bit;
    logic                  shift_en, complete, cnt_clr, push, drop;

`ifdef SSP_RX_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {SSPCLKIN, SSPFSSIN, SSPRXD};
            sync2_q <= sync1_q;
        end
    end

    assign pins = sync2_q;
`else
    assign pins = {SSPCLKIN, SSPFSSIN, SSPRXD};
`endif

    // NOTE: flops use non-blocking assignments and an async active-low clear so every
    // register updates from pre-edge values and drops to zero without waiting for PCLK.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            clk_q      <= 1'b0;
            fss_q      <= 1'b0;
            rxd_q      <= 1'b0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_q      <= pins[2];
            fss_q      <= pins[1];
            rxd_q      <= pins[0];
            clk_prev_q <= clk_q;
        end
    end

    assign sample   = clk_prev_q & ~clk_q;
    assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (sample && fss_q)                state_d = SHIFT;
            SHIFT: if (sample && !fss_q && last_bit)   state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // An FSS sample on the final bit completes the byte and opens the next frame at once.
    always_comb begin
        shift_en = 1'b0;
        complete = 1'b0;
        cnt_clr  = 1'b0;
        if (sample) begin
            if (state_q == SHIFT && (!fss_q || last_bit)) begin
                shift_en = 1'b1;
                complete = last_bit;
            end
            cnt_clr = fss_q || (shift_en && last_bit);
        end
        push = complete && VALID;
        drop = complete && !VALID;
    end

    always_comb begin
        shift_d = shift_en ? {shift_q[DATA_WIDTH-2:0], rxd_q} : shift_q;
        cnt_d   = cnt_q;
        if (cnt_clr)       cnt_d = '0;
        else if (shift_en) cnt_d = cnt_q + CNT_W'(1);
        data_d  = push ? shift_d : data_q;
        recv_d  = push;
        ovr_d   = drop ? 1'b1 : (RXOVR_CLR ? 1'b0 : ovr_q);
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            recv_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            recv_q  <= recv_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RxDATA = data_q;
    assign RECV   = recv_q;
    assign RXOVR  = ovr_q;
    assign RXBUSY = (state_q == SHIFT);

endmodule

// File: tb/tb_ssp_rx_logic.sv
// tb_ssp_rx_logic: directed and random serial slots against a bit-slot level frame model.
// Build with SSP_RX_SYNC_EN defined to exercise the synchronised variant (2 extra cycles).
module tb_ssp_rx_logic;

    localparam int DW = 8;
`ifdef SSP_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          PCLK = 1'b0;
    logic          CLEAR_B = 1'b0;
    logic          SSPCLKIN = 1'b0;
    logic          SSPFSSIN = 1'b0;
    logic          SSPRXD = 1'b0;
    logic          VALID = 1'b1;
    logic          RXOVR_CLR = 1'b0;
    logic [DW-1:0] RxDATA;
    logic          RECV;
    logic          RXOVR;
    logic          RXBUSY;

    ssp_rx_logic #(.DATA_WIDTH(DW), .CNT_W(4)) dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .VALID     (VALID),
        .RXOVR_CLR (RXOVR_CLR),
        .RxDATA    (RxDATA),
        .RECV      (RECV),
        .RXOVR     (RXOVR),
        .RXBUSY    (RXBUSY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: one entry per SSPCLKIN period (slot)
    bit            m_busy = 0;
    int            m_n = 0;
    logic [DW-1:0] m_byte = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_ovr = 0;
    bit            m_last_drop = 0;
    bit            prev_v = 1;
    logic [DW-1:0] exp_data[$];
    int            exp_cyc[$];

    task automatic model_reset();
        m_busy = 0; m_n = 0; m_byte = '0; m_data = '0; m_ovr = 0; m_last_drop = 0;
        exp_data.delete();
        exp_cyc.delete();
    endtask

    task automatic model_slot(input bit fss, input bit rxd, input bit v, input int fall);
        m_last_drop = 0;
        if (!m_busy) begin
            if (fss) begin m_busy = 1; m_n = 0; end
        end else if (fss && m_n != DW - 1) begin
            m_n = 0;
        end else begin
            m_byte = {m_byte[DW-2:0], rxd};
            m_n++;
            if (m_n == DW) begin
                m_n = 0;
                if (!fss) m_busy = 0;
                if (v) begin
                    m_data = m_byte;
                    exp_data.push_back(m_byte);
                    exp_cyc.push_back(fall + 2 + LAT);
                end else begin
                    m_ovr = 1;
                    m_last_drop = 1;
                end
            end
        end
    endtask

    always @(negedge PCLK) begin
        if (CLEAR_B && RECV) begin
            check("recv_expected", 32'(exp_data.size() > 0), 1);
            if (exp_data.size() > 0) begin
                check("recv_data", 32'(RxDATA), 32'(exp_data.pop_front()));
                check("recv_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
            end
        end
    end

    // One SSPCLKIN period: high 2 cycles, low 2 cycles; fall is driven after edge k.
    task automatic do_slot(input bit fss, input bit rxd, input bit v, input bit clr);
        int fall;
        @(posedge PCLK); #1;
        SSPCLKIN = 1'b1; SSPFSSIN = fss; SSPRXD = rxd; RXOVR_CLR = clr;
        if (clr) m_ovr = 0;
        @(posedge PCLK); #1;
        RXOVR_CLR = 1'b0;
        if (LAT != 0) VALID = prev_v;
        @(posedge PCLK); #1;
        SSPCLKIN = 1'b0;
        fall = cyc;
        @(posedge PCLK); #1;
        if (LAT == 0) VALID = v;
        check("rxbusy", 32'(RXBUSY), 32'(m_busy));
        check("rxovr", 32'(RXOVR), 32'(m_ovr));
        check("rxdata_hold", 32'(RxDATA), 32'(m_data));
        model_slot(fss, rxd, v, fall);
        prev_v = v;
    endtask

    task automatic send_bits(input logic [DW-1:0] b, input bit v, input bit fss_on_lsb);
        logic [DW-1:0] bb;
        bb = b;
        for (int i = DW - 1; i >= 0; i--)
            do_slot((i == 0) ? fss_on_lsb : 1'b0, bb[i], (i == 0) ? v : 1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input bit v);
        do_slot(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        send_bits(b, v, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_slot(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxdata"}, 32'(RxDATA), 0);
        check({tag, "_recv"}, 32'(RECV), 0);
        check({tag, "_rxovr"}, 32'(RXOVR), 0);
        check({tag, "_rxbusy"}, 32'(RXBUSY), 0);
    endtask

    // Asynchronous reset asserted mid-cycle while SSPCLKIN keeps toggling.
    task automatic mid_reset();
        @(posedge PCLK); #1;
        SSPCLKIN = 1'b1; SSPFSSIN = 1'b0;
        #3 CLEAR_B = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge PCLK); #1;
        SSPCLKIN = 1'b0;
        @(posedge PCLK); #1;
        CLEAR_B = 1'b1;
        model_reset();
    endtask

    initial begin
        #1 check_reset_outputs("por");
        repeat (3) @(posedge PCLK);
        #1 CLEAR_B = 1'b1;
        idle(2);

        // Single frame
        send_frame(8'hA5, 1'b1);
        idle(1);
        // Back-to-back: FSS during the LSB of 3C
        do_slot(1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(8'h3C, 1'b1, 1'b1);
        send_bits(8'hC3, 1'b1, 1'b0);
        idle(1);
        // Overrun, clear, recovery
        send_frame(8'h5A, 1'b0);
        idle(1);
        do_slot(1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h11, 1'b1);
        idle(1);
        // Abort after 4 bits
        do_slot(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_slot(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        send_frame(8'h81, 1'b1);
        idle(1);
        // Overrun so RXOVR is set, then reset in the middle of a frame
        send_frame(8'h77, 1'b0);
        idle(1);
        do_slot(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_slot(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        mid_reset();
        send_frame(8'hF0, 1'b1);
        idle(2);

        // Random slots
        for (int s = 0; s < 300; s++) begin
            bit f, c, v, d;
            f = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 9) == 0) && !m_last_drop;
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            do_slot(f, d, v, c);
        end
        idle(4);
        check("pending_recv", 32'(exp_data.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
